// File: rtl/conv_itlv_pkg.sv
// rtl/conv_itlv_pkg.sv - mode type and compile-time branch geometry for conv_itlv
package conv_itlv_pkg;

    typedef enum logic {
        ITLV_DEINT = 1'b0,
        ITLV_INT   = 1'b1
    } itlv_mode_e;

    function automatic int mem_depth(input int nbr, input int m);
        return m * nbr * (nbr - 1) / 2;
    endfunction

    function automatic int addr_width(input int nbr, input int m);
        int d;
        d = mem_depth(nbr, m);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    function automatic int br_len(input int j, input int nbr, input int m, input itlv_mode_e mode);
        return (mode == ITLV_INT) ? j * m : (nbr - 1 - j) * m;
    endfunction

    // Regions are packed back to back in branch order, so base(j) is the sum of earlier lengths.
    function automatic int br_base(input int j, input int nbr, input int m, input itlv_mode_e mode);
        int acc;
        acc = 0;
        for (int k = 0; k < j; k++) begin
            acc += br_len(k, nbr, m, mode);
        end
        return acc;
    endfunction

endpackage

// File: rtl/conv_itlv_ram.sv
// rtl/conv_itlv_ram.sv - simple dual-port RAM, synchronous read-first, no reset
module conv_itlv_ram #(
    parameter int DW    = 8,
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] rd
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
        if (re) begin
            rd <= mem[ra];
        end
    end

endmodule

// File: rtl/conv_itlv.sv
// rtl/conv_itlv.sv - Forney convolutional (de)interleaver; CONV_ITLV_SYNC_ALIGN_EN enables sync realignment
module conv_itlv
    import conv_itlv_pkg::*;
#(
    parameter int DW  = 8,
    parameter int NBR = 12,
    parameter int M   = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          itlv_mode,
    input  logic          sym_ena,
    input  logic          sym_sync,
    input  logic [DW-1:0] sym_din,
    output logic          sym_vld,
    output logic [DW-1:0] sym_dout,
    output logic          sym_br0
);

    localparam int MEM_D = mem_depth(NBR, M);
    localparam int AW    = addr_width(NBR, M);
    localparam int BW    = $clog2(NBR);

    itlv_mode_e     mode_q;
    logic [BW-1:0]  br;
    logic [BW-1:0]  bsel;
    logic [BW-1:0]  br_nxt;
    logic [AW-1:0]  ptr [NBR];
    logic [NBR-1:0] primed;

    logic [AW-1:0]  base_s [NBR];
    logic [AW-1:0]  lm1_s  [NBR];
    logic [NBR-1:0] zero_s;

    logic [AW-1:0]  addr;
    logic           byp;
    logic           ram_en;
    logic [DW-1:0]  ram_rd;

    logic           v1;
    logic           byp1;
    logic           prim1;
    logic           b01;
    logic [DW-1:0]  din1;

    // Both geometries are constants; the latched mode only steers a mux.
    for (genvar j = 0; j < NBR; j++) begin : g_geo
        localparam int LD = br_len(j, NBR, M, ITLV_DEINT);
        localparam int LI = br_len(j, NBR, M, ITLV_INT);
        localparam int BD = br_base(j, NBR, M, ITLV_DEINT);
        localparam int BI = br_base(j, NBR, M, ITLV_INT);

        assign base_s[j] = (mode_q == ITLV_INT) ? AW'(LI > 0 ? BI : 0) : AW'(LD > 0 ? BD : 0);
        assign lm1_s[j]  = (mode_q == ITLV_INT) ? AW'(LI > 0 ? LI - 1 : 0) : AW'(LD > 0 ? LD - 1 : 0);
        assign zero_s[j] = (mode_q == ITLV_INT) ? (LI == 0) : (LD == 0);
    end

`ifdef CONV_ITLV_SYNC_ALIGN_EN
    always_comb begin
        bsel = br;
        if (sym_sync) begin
            bsel = '0;
        end
    end
`else
    logic unused_sync;
    assign unused_sync = sym_sync;

    always_comb begin
        bsel = br;
    end
`endif

    always_comb begin
        br_nxt = bsel + 1'b1;
        if (bsel == BW'(NBR - 1)) begin
            br_nxt = '0;
        end
    end

    assign addr   = base_s[bsel] + ptr[bsel];
    assign byp    = zero_s[bsel];
    assign ram_en = sym_ena & rst_n & ~byp;

    conv_itlv_ram #(
        .DW    (DW),
        .DEPTH (MEM_D),
        .AW    (AW)
    ) u_ram (
        .clk (clk),
        .we  (ram_en),
        .wa  (addr),
        .wd  (sym_din),
        .re  (ram_en),
        .ra  (addr),
        .rd  (ram_rd)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q <= itlv_mode_e'(itlv_mode);
            br     <= '0;
            primed <= '0;
            for (int j = 0; j < NBR; j++) begin
                ptr[j] <= '0;
            end
        end else if (sym_ena) begin
            br <= br_nxt;
            if (!byp) begin
                if (ptr[bsel] == lm1_s[bsel]) begin
                    ptr[bsel]    <= '0;
                    primed[bsel] <= 1'b1;
                end else begin
                    ptr[bsel] <= ptr[bsel] + 1'b1;
                end
            end
        end
    end

    // Stage 1 carries the side information alongside the synchronous RAM read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            byp1  <= 1'b0;
            prim1 <= 1'b0;
            b01   <= 1'b0;
            din1  <= '0;
        end else begin
            v1 <= sym_ena;
            if (sym_ena) begin
                byp1  <= byp;
                prim1 <= primed[bsel];
                b01   <= (bsel == '0);
                din1  <= sym_din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sym_vld  <= 1'b0;
            sym_dout <= '0;
            sym_br0  <= 1'b0;
        end else begin
            sym_vld <= v1;
            sym_br0 <= v1 & b01;
            if (v1) begin
                sym_dout <= byp1 ? din1 : (prim1 ? ram_rd : '0);
            end
        end
    end

endmodule

// File: tb/tb_conv_itlv.sv
// tb/tb_conv_itlv.sv - self-checking bench for conv_itlv
`timescale 1ns/1ps
module tb_conv_itlv;

    localparam int NA = 3;
    localparam int MA = 2;
    localparam int NP = 4;
    localparam int MP = 3;
    localparam int PD = NP * (NP - 1) * MP;
    localparam int PN = 400;
`ifdef CONV_ITLV_SYNC_ALIGN_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n = 1'b0, a_mode = 1'b0, a_ena = 1'b0, a_sync = 1'b0;
    logic [7:0] a_din = '0;
    logic       a_vld, a_br0;
    logic [7:0] a_dout;

    logic       p_rst_n = 1'b0, p_ena = 1'b0, p_sync = 1'b0;
    logic [7:0] p_din = '0;
    logic       b_vld, b_br0, c_vld, c_br0;
    logic [7:0] b_dout, c_dout;

    conv_itlv #(.DW(8), .NBR(NA), .M(MA)) u_a (
        .clk(clk), .rst_n(a_rst_n), .itlv_mode(a_mode), .sym_ena(a_ena), .sym_sync(a_sync),
        .sym_din(a_din), .sym_vld(a_vld), .sym_dout(a_dout), .sym_br0(a_br0));

    conv_itlv #(.DW(8), .NBR(NP), .M(MP)) u_b (
        .clk(clk), .rst_n(p_rst_n), .itlv_mode(1'b1), .sym_ena(p_ena), .sym_sync(p_sync),
        .sym_din(p_din), .sym_vld(b_vld), .sym_dout(b_dout), .sym_br0(b_br0));

    conv_itlv #(.DW(8), .NBR(NP), .M(MP)) u_c (
        .clk(clk), .rst_n(p_rst_n), .itlv_mode(1'b0), .sym_ena(b_vld), .sym_sync(b_br0),
        .sym_din(b_dout), .sym_vld(c_vld), .sym_dout(c_dout), .sym_br0(c_br0));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: each branch is an unbounded history; output is the entry len(b) visits back, 0 before that.
    logic [7:0] hist [NA][4096];
    int         vis [NA];
    int         mbr;
    bit         mmode;

    function automatic int blen(input int j);
        return mmode ? j * MA : (NA - 1 - j) * MA;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < NA; j++) vis[j] = 0;
        mbr = 0;
    endtask

    task automatic model_sym(input logic [7:0] din, input logic sync, output logic [7:0] d, output logic b0);
        int b, l;
        b = (SYNC_EN && sync) ? 0 : mbr;
        l = blen(b);
        hist[b][vis[b]] = din;
        d = (vis[b] >= l) ? hist[b][vis[b] - l] : 8'h00;
        vis[b]++;
        b0 = (b == 0);
        mbr = (b + 1) % NA;
    endtask

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       b0;
    } exp_t;
    exp_t e1 = '0, e2 = '0;

    task automatic step(input logic ena, input logic sync, input logic rst, input logic [7:0] din,
                        input logic use_tab, input logic [7:0] tab_d, input string tag);
        exp_t n;
        @(negedge clk);
        chk({tag, "_vld"}, int'(a_vld), int'(e2.v));
        if (e2.v) begin
            chk({tag, "_dout"}, int'(a_dout), int'(e2.d));
            chk({tag, "_br0"}, int'(a_br0), int'(e2.b0));
        end
        e2 = e1;
        n  = '0;
        a_rst_n = !rst;
        a_ena   = ena;
        a_sync  = sync;
        a_din   = din;
        if (rst) begin
            e2    = '0;
            mmode = a_mode;
            model_reset();
        end else if (ena) begin
            model_sym(din, sync, n.d, n.b0);
            n.v = 1'b1;
            if (use_tab) n.d = tab_d;
        end
        e1 = n;
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;
    vec_t vt [12];
    logic [7:0] exp_list [12] = '{8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd6, 8'd0, 8'd2, 8'd9, 8'd0, 8'd5, 8'd12};

    logic [7:0] pin [PN];
    bit         p_mon = 1'b0;
    int         p_cnt = 0;

    always @(negedge clk) begin
        if (p_mon && c_vld) begin
            chk("pair_dout", int'(c_dout), (p_cnt >= PD) ? int'(pin[p_cnt - PD]) : 0);
            chk("pair_br0", int'(c_br0), int'(p_cnt % NP == 0));
            p_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 12; i++) begin
            vt[i].din  = 8'(i + 1);
            vt[i].dout = exp_list[i];
        end

        a_mode = 1'b0;
        step(0, 0, 1, 0, 0, 0, "rst");
        step(0, 0, 1, 0, 0, 0, "rst");
        @(negedge clk);
        chk("reset_vld", int'(a_vld), 0);
        chk("reset_dout", int'(a_dout), 0);
        chk("reset_br0", int'(a_br0), 0);

        for (int i = 0; i < 12; i++) step(1, 0, 0, vt[i].din, 1, vt[i].dout, "table");

        for (int i = 0; i < 300; i++) begin
            a_mode = 1'($urandom);
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0), 0, 8'($urandom), 0, 0, "rand");
        end

        a_mode = 1'b0;
        step(0, 0, 1, 0, 0, 0, "rst");
        step(1, 0, 0, 8'h11, 0, 0, "sync");
        step(1, 0, 0, 8'h22, 0, 0, "sync");
        step(1, 1, 0, 8'h33, 0, 0, "sync");
        step(1, 0, 0, 8'h44, 0, 0, "sync");
        step(1, 1, 0, 8'h55, 0, 0, "sync");
        step(1, 0, 0, 8'h66, 0, 0, "sync");

        for (int i = 0; i < 500; i++) step(1, ($urandom_range(0, 15) == 0), 0, 8'($urandom), 0, 0, "pre_rst");
        a_mode = 1'b1;
        step(0, 0, 1, 0, 0, 0, "midrst");
        for (int i = 0; i < 300; i++) begin
            a_mode = 1'($urandom);
            step(1, 0, 0, 8'($urandom), 0, 0, "post_rst");
        end

        a_mode = 1'b0;
        step(0, 0, 1, 0, 0, 0, "rst");
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, vt[i].din, 1, vt[i].dout, "sparse");
            step(0, 0, 0, 0, 0, 0, "sparse");
            step(0, 0, 0, 0, 0, 0, "sparse");
        end
        step(0, 0, 0, 0, 0, 0, "flush");
        step(0, 0, 0, 0, 0, 0, "flush");
        step(0, 0, 0, 0, 0, 0, "flush");

        @(negedge clk);
        p_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        p_rst_n = 1'b1;
        p_mon   = 1'b1;
        for (int k = 0; k < PN; k++) begin
            pin[k] = 8'(k);
            p_din  = 8'(k);
            p_ena  = 1'b1;
            p_sync = (k % NP == 0);
            @(negedge clk);
        end
        p_ena  = 1'b0;
        p_sync = 1'b0;
        repeat (8) @(negedge clk);
        chk("pair_count", p_cnt, PN);
        p_mon = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
